bram_arbiter: RTL and testbench
===============================

Name: bram_arbiter

Overview:
Two-client arbiter sharing one single-clock BRAM (registered read, 1-cycle latency, separate write/read address ports, one operation per cycle issued by this block). Each client issues single-beat read or write requests under a Req/Gnt handshake. Arbitration is round-robin with bounded burst ownership. The block sits between two datapath masters (e.g. a producer and a consumer FSM) and the BRAM instance.

Parameters:
Data_Width, 8, BRAM word width
Addr_Width, 4, BRAM address width
MAX_BURST, 4, max consecutive grants to one client while the other is requesting (>=1)

Ports:
i_Clk  input  1  system clock
i_Rst_n  input  1  asynchronous active-low reset
A_Req  input  1  client A request; held with A_We/A_Addr/A_Wr_Data stable until A_Gnt
A_We  input  1  1 = write, 0 = read
A_Addr  input  Addr_Width  client A address
A_Wr_Data  input  Data_Width  client A write data
A_Gnt  output  1  request accepted this cycle (combinational)
A_Rd_Valid  output  1  read data valid for client A (registered)
A_Rd_Data  output  Data_Width  read data for client A
B_Req, B_We, B_Addr, B_Wr_Data, B_Gnt, B_Rd_Valid, B_Rd_Data: same as client A
Wr_En  output  1  to BRAM
Rd_En  output  1  to BRAM
W_Addr  output  Addr_Width  to BRAM
R_Addr  output  Addr_Width  to BRAM
Wr_Data  output  Data_Width  to BRAM
Rd_Data  input  Data_Width  from BRAM, valid one cycle after Rd_En

Behaviour:
- Registered state: Own in {IDLE, OWN_A, OWN_B}; Cnt (clog2(MAX_BURST+1) bits); Last (last client granted); Rd_Tag_A, Rd_Tag_B.
- Reset (async, i_Rst_n=0): Own=IDLE, Cnt=0, Last=B (A wins first tie), A_Rd_Valid=B_Rd_Valid=0. Gnt and BRAM strobes are 0 while in reset. A read in flight at reset is dropped; no Rd_Valid after release.
- Grant decision (combinational, at most one Gnt per cycle):
  - No Req: no grant; next Own=IDLE, Cnt=0.
  - Only X requests: grant X. If Own==OWN_X, Cnt=min(Cnt+1, MAX_BURST); else Cnt=1. Next Own=OWN_X, Last=X.
  - Both request, Own==IDLE: grant the client != Last; Cnt=1.
  - Both request, Own==OWN_X, Cnt<MAX_BURST: grant X; Cnt+1.
  - Both request, Own==OWN_X, Cnt==MAX_BURST: grant other client Y; Own=OWN_Y, Cnt=1.
- Saturated Cnt with a lone requester keeps granting it; the other client is granted on the first cycle it requests.
- BRAM drive (combinational from granted client G): Wr_En=Gnt&We_G; Rd_En=Gnt&~We_G; W_Addr=R_Addr=Addr_G; Wr_Data=Wr_Data_G. With no grant: Wr_En=Rd_En=0; addresses/data = client A fields (don't-care).
- Read return: granted read in cycle N -> X_Rd_Valid=1 for exactly cycle N+1; X_Rd_Data=Rd_Data (both clients see the BRAM bus; only Rd_Valid qualifies). Back-to-back reads give back-to-back Rd_Valid.
- Ordering: one op per cycle, so a write in cycle N is visible to a read granted in cycle N+1 or later.
- Req deasserted without Gnt is legal (request withdrawn, no side effect). Gnt must never assert for a client with Req=0.

Test Plan:
- Reset: hold i_Rst_n=0 with A_Req=B_Req=1 -> A_Gnt=B_Gnt=0, Wr_En=Rd_En=0, Rd_Valid=0; release -> A_Gnt=1 first cycle.
- Write/read single client: A writes 0x5A to addr 3, then reads addr 3 -> Wr_En=1,W_Addr=3 cycle N; Rd_En=1 cycle N+1; A_Rd_Valid=1,A_Rd_Data=0x5A cycle N+2, B_Rd_Valid=0.
- Fairness, MAX_BURST=4: A_Req and B_Req held high for 16 cycles -> grants AAAA BBBB AAAA BBBB; never two Gnt in one cycle.
- Lone requester: only B requests for 10 cycles -> B_Gnt=1 all 10; A_Req rises in cycle 11 -> A_Gnt=1 in cycle 11.
- Interleaved reads: A reads addr 1 (0x11), B reads addr 2 (0x22) on alternating grants -> Rd_Valid routed to the right client one cycle after each grant with matching data.
- Reset mid-read: grant A read, assert i_Rst_n=0 next edge -> A_Rd_Valid stays 0; Own=IDLE, Cnt=0 after release.

Source files
------------

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin two-client BRAM arbiter with bounded burst ownership
module bram_arbiter #(
    parameter int Data_Width = 8,
    parameter int Addr_Width = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  A_Req,
    input  logic                  A_We,
    input  logic [Addr_Width-1:0] A_Addr,
    input  logic [Data_Width-1:0] A_Wr_Data,
    output logic                  A_Gnt,
    output logic                  A_Rd_Valid,
    output logic [Data_Width-1:0] A_Rd_Data,
    input  logic                  B_Req,
    input  logic                  B_We,
    input  logic [Addr_Width-1:0] B_Addr,
    input  logic [Data_Width-1:0] B_Wr_Data,
    output logic                  B_Gnt,
    output logic                  B_Rd_Valid,
    output logic [Data_Width-1:0] B_Rd_Data,
    output logic                  Wr_En,
    output logic                  Rd_En,
    output logic [Addr_Width-1:0] W_Addr,
    output logic [Addr_Width-1:0] R_Addr,
    output logic [Data_Width-1:0] Wr_Data,
    input  logic [Data_Width-1:0] Rd_Data
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} own_t;

    own_t            own_q, own_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_b_q, last_b_d;
    logic            rd_tag_a_q, rd_tag_b_q;
    logic [CW-1:0]   cnt_inc;
    logic            sel_we;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            own_q      <= IDLE;
            cnt_q      <= '0;
            last_b_q   <= 1'b1;
            rd_tag_a_q <= 1'b0;
            rd_tag_b_q <= 1'b0;
        end else begin
            own_q      <= own_d;
            cnt_q      <= cnt_d;
            last_b_q   <= last_b_d;
            rd_tag_a_q <= A_Gnt & ~A_We;
            rd_tag_b_q <= B_Gnt & ~B_We;
        end
    end

    assign cnt_inc = (cnt_q == MAXC) ? MAXC : cnt_q + CW'(1);

    always_comb begin
        own_d    = IDLE;
        cnt_d    = '0;
        last_b_d = last_b_q;
        if (A_Gnt) begin
            own_d    = OWN_A;
            last_b_d = 1'b0;
            cnt_d    = (own_q == OWN_A) ? cnt_inc : CW'(1);
        end else if (B_Gnt) begin
            own_d    = OWN_B;
            last_b_d = 1'b1;
            cnt_d    = (own_q == OWN_B) ? cnt_inc : CW'(1);
        end
    end

    // Grants are forced low while reset is asserted, even though state is already IDLE.
    always_comb begin
        A_Gnt = 1'b0;
        B_Gnt = 1'b0;
        if (i_Rst_n) begin
            if (A_Req && B_Req) begin
                case (own_q)
                    OWN_A:   if (cnt_q < MAXC) A_Gnt = 1'b1; else B_Gnt = 1'b1;
                    OWN_B:   if (cnt_q < MAXC) B_Gnt = 1'b1; else A_Gnt = 1'b1;
                    default: if (last_b_q) A_Gnt = 1'b1; else B_Gnt = 1'b1;
                endcase
            end else begin
                A_Gnt = A_Req;
                B_Gnt = B_Req;
            end
        end
        sel_we  = B_Gnt ? B_We : A_We;
        Wr_En   = (A_Gnt | B_Gnt) & sel_we;
        Rd_En   = (A_Gnt | B_Gnt) & ~sel_we;
        W_Addr  = B_Gnt ? B_Addr : A_Addr;
        R_Addr  = B_Gnt ? B_Addr : A_Addr;
        Wr_Data = B_Gnt ? B_Wr_Data : A_Wr_Data;
    end

    assign A_Rd_Valid = rd_tag_a_q;
    assign B_Rd_Valid = rd_tag_b_q;
    assign A_Rd_Data  = Rd_Data;
    assign B_Rd_Data  = Rd_Data;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - randomized self-checking bench for bram_arbiter
module tb_bram_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wd, b_wd;
    logic a_gnt, b_gnt, a_rv, b_rv, wr_en, rd_en;
    logic [DW-1:0] a_rd, b_rd, wr_data;
    logic [AW-1:0] w_addr, r_addr;
    logic [DW-1:0] bram_q;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic mem_clr;

    bram_arbiter #(.Data_Width(DW), .Addr_Width(AW), .MAX_BURST(MB)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .A_Req(a_req), .A_We(a_we), .A_Addr(a_addr), .A_Wr_Data(a_wd),
        .A_Gnt(a_gnt), .A_Rd_Valid(a_rv), .A_Rd_Data(a_rd),
        .B_Req(b_req), .B_We(b_we), .B_Addr(b_addr), .B_Wr_Data(b_wd),
        .B_Gnt(b_gnt), .B_Rd_Valid(b_rv), .B_Rd_Data(b_rd),
        .Wr_En(wr_en), .Rd_En(rd_en), .W_Addr(w_addr), .R_Addr(r_addr),
        .Wr_Data(wr_data), .Rd_Data(bram_q)
    );

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
        end else begin
            if (wr_en) mem[w_addr] <= wr_data;
            if (rd_en) bram_q <= mem[r_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0=none 1=A 2=B, streak of consecutive grants, last granted client.
    int m_own, m_streak, m_last;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    logic obs_ga, obs_gb, obs_wen, obs_ren, obs_rva, obs_rvb;
    logic [AW-1:0] obs_wa, obs_ra;
    logic [DW-1:0] obs_wd, obs_rda, obs_rdb;
    logic exp_ga, exp_gb, exp_wen, exp_ren, exp_rva, exp_rvb;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, exp_rdata;
    int last_g;

    task automatic model_reset();
        m_own = 0; m_streak = 0; m_last = 2;
    endtask

    task automatic do_cycle(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                            input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        int g;
        logic we;
        @(negedge clk);
        a_req = ar; a_we = aw; a_addr = aa; a_wd = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wd = bd;
        #1;
        obs_ga = a_gnt; obs_gb = b_gnt; obs_wen = wr_en; obs_ren = rd_en;
        obs_wa = w_addr; obs_ra = r_addr; obs_wd = wr_data;
        g = 0;
        if (!rst_n) g = 0;
        else if (ar && br) begin
            if (m_own == 0) g = (m_last == 1) ? 2 : 1;
            else if (m_streak < MB) g = m_own;
            else g = 3 - m_own;
        end else if (ar) g = 1;
        else if (br) g = 2;
        last_g = g;
        exp_ga = (g == 1); exp_gb = (g == 2);
        we = (g == 2) ? bw : aw;
        exp_wen = (g != 0) && we;
        exp_ren = (g != 0) && !we;
        exp_addr = (g == 2) ? ba : aa;
        exp_wd = (g == 2) ? bd : ad;
        @(posedge clk); #1;
        obs_rva = a_rv; obs_rvb = b_rv; obs_rda = a_rd; obs_rdb = b_rd;
        exp_rva = (g == 1) && !aw;
        exp_rvb = (g == 2) && !bw;
        exp_rdata = ref_mem[exp_addr];
        if (exp_wen) ref_mem[exp_addr] = exp_wd;
        if (!rst_n) model_reset();
        else if (g != 0) begin
            m_streak = (m_own == g) ? ((m_streak + 1 > MB) ? MB : m_streak + 1) : 1;
            m_own = g; m_last = g;
        end else begin
            m_own = 0; m_streak = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, 0, 4'(i), 8'h00, 1, 1, 4'(i), 8'hFF);
            checks++;
            if ({obs_ga, obs_gb, obs_wen, obs_ren} !== 4'b0000) begin
                errors++; $display("FAIL reset_strobes got=%b want=0000", {obs_ga, obs_gb, obs_wen, obs_ren});
            end
            checks++;
            if ({obs_rva, obs_rvb} !== 2'b00) begin
                errors++; $display("FAIL reset_rd_valid got=%b want=00", {obs_rva, obs_rvb});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_cycle(1, 0, 4'd0, 8'h00, 1, 0, 4'd1, 8'h00);
        checks++;
        if ({obs_ga, obs_gb} !== 2'b10) begin
            errors++; $display("FAIL reset_first_grant got=%b want=10", {obs_ga, obs_gb});
        end
    endtask

    task automatic test_write_read();
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1, 1, 4'd3, 8'h5A, 0, 0, 0, 0);
        checks++;
        if ({obs_wen, obs_ren, obs_wa, obs_wd} !== {1'b1, 1'b0, 4'd3, 8'h5A}) begin
            errors++; $display("FAIL wr_strobe got=%b%b/%h/%h want=10/3/5a", obs_wen, obs_ren, obs_wa, obs_wd);
        end
        do_cycle(1, 0, 4'd3, 8'h00, 0, 0, 0, 0);
        checks++;
        if ({obs_wen, obs_ren, obs_ra} !== {1'b0, 1'b1, 4'd3}) begin
            errors++; $display("FAIL rd_strobe got=%b%b/%h want=01/3", obs_wen, obs_ren, obs_ra);
        end
        checks++;
        if ({obs_rva, obs_rvb, obs_rda} !== {1'b1, 1'b0, 8'h5A}) begin
            errors++; $display("FAIL rd_return got=%b%b/%h want=10/5a", obs_rva, obs_rvb, obs_rda);
        end
    endtask

    task automatic test_fairness();
        int first;
        int want;
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        first = (m_last == 1) ? 2 : 1;
        for (int i = 0; i < 16; i++) begin
            do_cycle(1, 0, 4'($urandom_range(0, 15)), 0, 1, 0, 4'($urandom_range(0, 15)), 0);
            want = ((i / MB) % 2 == 0) ? first : 3 - first;
            checks++;
            if ({obs_ga, obs_gb} !== {want == 1, want == 2}) begin
                errors++; $display("FAIL fairness_cycle%0d got=%b%b want_client=%0d", i, obs_ga, obs_gb, want);
            end
            checks++;
            if ({obs_rva, obs_rvb} !== {exp_rva, exp_rvb} || obs_rda !== exp_rdata) begin
                errors++; $display("FAIL fairness_rd got=%b%b/%h want=%b%b/%h", obs_rva, obs_rvb, obs_rda, exp_rva, exp_rvb, exp_rdata);
            end
        end
    endtask

    task automatic test_lone_requester();
        for (int i = 0; i < 10; i++) begin
            do_cycle(0, 0, 0, 0, 1, 1, 4'(i), 8'(i + 8'h40));
            checks++;
            if ({obs_ga, obs_gb} !== 2'b01) begin
                errors++; $display("FAIL lone_b_cycle%0d got=%b%b want=01", i, obs_ga, obs_gb);
            end
        end
        do_cycle(1, 0, 4'd5, 0, 1, 0, 4'd6, 0);
        checks++;
        if ({obs_ga, obs_gb} !== 2'b10) begin
            errors++; $display("FAIL lone_a_arrives got=%b%b want=10", obs_ga, obs_gb);
        end
    endtask

    task automatic test_interleaved_reads();
        do_cycle(1, 1, 4'd1, 8'h11, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 1, 1, 4'd2, 8'h22);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) do_cycle(1, 0, 4'd1, 0, 0, 0, 0, 0);
            else            do_cycle(0, 0, 0, 0, 1, 0, 4'd2, 0);
            checks++;
            if (i % 2 == 0) begin
                if ({obs_rva, obs_rvb, obs_rda} !== {1'b1, 1'b0, 8'h11}) begin
                    errors++; $display("FAIL interleave_a%0d got=%b%b/%h want=10/11", i, obs_rva, obs_rvb, obs_rda);
                end
            end else begin
                if ({obs_rva, obs_rvb, obs_rdb} !== {1'b0, 1'b1, 8'h22}) begin
                    errors++; $display("FAIL interleave_b%0d got=%b%b/%h want=01/22", i, obs_rva, obs_rvb, obs_rdb);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 4'd1; b_req = 0;
        #1;
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++; $display("FAIL midread_grant got=%b want=1", a_gnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        a_req = 0;
        #1;
        checks++;
        if (a_rv !== 1'b0) begin
            errors++; $display("FAIL midread_valid_dropped got=%b want=0", a_rv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * MB; i++) begin
            do_cycle(1, 1, 4'd9, 8'(i), 1, 1, 4'd10, 8'(i));
            checks++;
            if ({obs_ga, obs_gb, obs_rva, obs_rvb} !== {i < MB, i >= MB, 1'b0, 1'b0}) begin
                errors++; $display("FAIL midread_restart%0d got=%b want_a=%0d", i, {obs_ga, obs_gb, obs_rva, obs_rvb}, i < MB);
            end
        end
    endtask

    task automatic test_random();
        logic ar, br;
        for (int i = 0; i < 300; i++) begin
            ar = 1'($urandom_range(0, 3) != 0);
            br = 1'($urandom_range(0, 3) != 0);
            do_cycle(ar, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                     br, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            checks++;
            if ({obs_ga, obs_gb, obs_wen, obs_ren} !== {exp_ga, exp_gb, exp_wen, exp_ren}) begin
                errors++; $display("FAIL rand_grant%0d got=%b want=%b", i, {obs_ga, obs_gb, obs_wen, obs_ren}, {exp_ga, exp_gb, exp_wen, exp_ren});
            end
            if (last_g != 0) begin
                checks++;
                if (obs_wa !== exp_addr || obs_ra !== exp_addr || (exp_wen && obs_wd !== exp_wd)) begin
                    errors++; $display("FAIL rand_bus%0d got=%h/%h/%h want=%h/%h", i, obs_wa, obs_ra, obs_wd, exp_addr, exp_wd);
                end
            end
            checks++;
            if ({obs_rva, obs_rvb} !== {exp_rva, exp_rvb}) begin
                errors++; $display("FAIL rand_rd_valid%0d got=%b%b want=%b%b", i, obs_rva, obs_rvb, exp_rva, exp_rvb);
            end
            if (exp_rva || exp_rvb) begin
                checks++;
                if ((exp_rva ? obs_rda : obs_rdb) !== exp_rdata) begin
                    errors++; $display("FAIL rand_rd_data%0d got=%h want=%h", i, exp_rva ? obs_rda : obs_rdb, exp_rdata);
                end
            end
        end
    endtask

    initial begin
        a_req = 0; a_we = 0; a_addr = '0; a_wd = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wd = '0;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
        model_reset();
        mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        test_reset();
        test_write_read();
        test_fairness();
        test_lone_requester();
        test_interleaved_reads();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
